// File: rtl/npu_mem_pkg.sv
// Shared constants and helpers for the NPU buffer memory wrappers.
package npu_mem_pkg;

  localparam int GRANT_CNT_W = 32;

  // Index width for a round-robin pointer over n requesters (at least one bit).
  function automatic int RR_IDX_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the last
// granted index, with the pointer held when nothing is granted.
module rr_arbiter
  import npu_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = RR_IDX_W(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);

  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  logic [IW-1:0] last;
  logic [IW-1:0] pos;

  // Search last+1, last+2, ... (mod NUM_REQ) for the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IW'((int'(last) + k) % NUM_REQ);
      if (!grant_any && req[pos]) begin
        grant_any  = 1'b1;
        grant_idx  = pos;
        grant[pos] = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

  // Pointer starts at NUM_REQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= LAST_INIT;
    end else if (grant_any) begin
      last <= grant_idx;
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Shares the read port of a 1R1W RAM between NUM_REQ requesters with a uniform
// 1-cycle tagged response; same-cycle writes are forwarded to colliding reads.
module ram_rd_arbiter
  import npu_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int OUTPUT_REG = 0,
  localparam int IW = RR_IDX_W(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            rd_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]            rd_req_ready,
  output logic [NUM_REQ-1:0]            rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]         rd_rsp_data,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ram_reset,
  output logic                          ram_read_req,
  output logic [ADDR_WIDTH-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH-1:0]         ram_read_data,
  output logic                          ram_write_req,
  output logic [ADDR_WIDTH-1:0]         ram_write_addr,
  output logic [DATA_WIDTH-1:0]         ram_write_data,
  output logic [GRANT_CNT_W-1:0]        grant_count
);

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  collide;

  logic                  rsp_v;
  logic [IW-1:0]         rsp_idx;
  logic                  fwd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] cap_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (rd_req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign rd_req_ready   = grant;
  assign ram_reset      = ~reset;
  assign ram_read_req   = grant_any;
  assign ram_read_addr  = sel_addr;
  assign ram_write_req  = wr_valid;
  assign ram_write_addr = wr_addr;
  assign ram_write_data = wr_data;
  assign collide        = grant_any && wr_valid && (wr_addr == sel_addr);

  // Address of the granted requester; zero when idle.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        sel_addr = sel_addr;
      end
    end
  end

  // Response tag, forwarding capture and grant counter; all hold while idle so
  // the response data mux keeps presenting the last response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_v       <= 1'b0;
      rsp_idx     <= '0;
      fwd         <= 1'b0;
      fwd_data    <= '0;
      grant_count <= '0;
    end else if (grant_any) begin
      rsp_v       <= 1'b1;
      rsp_idx     <= grant_idx;
      fwd         <= collide;
      fwd_data    <= collide ? wr_data : fwd_data;
      grant_count <= grant_count + GRANT_CNT_W'(1);
    end else begin
      rsp_v       <= 1'b0;
      rsp_idx     <= rsp_idx;
      fwd         <= fwd;
      fwd_data    <= fwd_data;
      grant_count <= grant_count;
    end
  end

  // A combinational-read RAM needs its data captured to align with the response cycle.
  if (OUTPUT_REG == 0) begin : g_cap
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cap_data <= '0;
      end else if (grant_any) begin
        cap_data <= ram_read_data;
      end else begin
        cap_data <= cap_data;
      end
    end
  end else begin : g_nocap
    assign cap_data = '0;
  end

  // One-hot response strobe decoded from the registered tag.
  always_comb begin
    rd_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_rsp_valid[i] = rsp_v && (rsp_idx == IW'(i));
    end
  end

  // Response data source: forwarded write, registered RAM output, or captured read.
  always_comb begin
    rd_rsp_data = cap_data;
    if (fwd) begin
      rd_rsp_data = fwd_data;
    end else if (OUTPUT_REG != 0) begin
      rd_rsp_data = ram_read_data;
    end else begin
      rd_rsp_data = cap_data;
    end
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Self-checking bench: drives the arbiter in both RAM read modes side by side
// and compares against a round-robin/memory reference model.
module tb_ram_rd_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  rd_req_valid;
  logic [N*AW-1:0] rd_req_addr;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [N-1:0]  ready_a, rspv_a, ready_b, rspv_b;
  logic [DW-1:0] rspd_a, rspd_b;
  logic          rrst_a, rreq_a, wreq_a, rrst_b, rreq_b, wreq_b;
  logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
  logic [DW-1:0] rdata_a, wdata_a, rdata_b, wdata_b;
  logic [31:0]   gcnt_a, gcnt_b;

  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  logic [DW-1:0] q_b;

  // reference model state
  int            m_last;
  int unsigned   m_cnt;
  logic [N-1:0]  m_v;
  logic [DW-1:0] m_d;
  logic [N-1:0]  m_grant;
  logic [DW-1:0] m_mem [0:4095];
  logic [N-1:0]  obs_rdy_a, obs_rdy_b;

  int total;
  int bad;

  always #5 clk = ~clk;

  ram_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(0)) dut_comb (
    .clk(clk), .reset(reset), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_ready(ready_a), .rd_rsp_valid(rspv_a), .rd_rsp_data(rspd_a),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_reset(rrst_a), .ram_read_req(rreq_a), .ram_read_addr(raddr_a), .ram_read_data(rdata_a),
    .ram_write_req(wreq_a), .ram_write_addr(waddr_a), .ram_write_data(wdata_a),
    .grant_count(gcnt_a)
  );

  ram_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(1)) dut_reg (
    .clk(clk), .reset(reset), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_ready(ready_b), .rd_rsp_valid(rspv_b), .rd_rsp_data(rspd_b),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_reset(rrst_b), .ram_read_req(rreq_b), .ram_read_addr(raddr_b), .ram_read_data(rdata_b),
    .ram_write_req(wreq_b), .ram_write_addr(waddr_b), .ram_write_data(wdata_b),
    .grant_count(gcnt_b)
  );

  // RAM with combinational read
  always @(posedge clk) if (wreq_a) mem_a[waddr_a] <= wdata_a;
  assign rdata_a = mem_a[raddr_a];

  // RAM with registered read (read-before-write, reset clears the output register)
  always @(posedge clk) if (wreq_b) mem_b[waddr_b] <= wdata_b;
  always @(posedge clk or posedge rrst_b) begin
    if (rrst_b) q_b <= '0;
    else if (rreq_b) q_b <= mem_b[raddr_b];
  end
  assign rdata_b = q_b;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_cnt  = 0;
    m_v    = '0;
    m_d    = '0;
  endtask

  task automatic set_addrs(input int base);
    for (int i = 0; i < N; i++) rd_req_addr[i*AW +: AW] = AW'(base + i);
  endtask

  // One clock: sample ready before the edge, advance the model at the edge.
  // A write is visible to a read granted on the same edge.
  task automatic cycle();
    int g;
    #1;
    g = rr_pick(rd_req_valid, m_last);
    m_grant = '0;
    if (g >= 0) m_grant[g] = 1'b1;
    obs_rdy_a = ready_a;
    obs_rdy_b = ready_b;
    @(posedge clk);
    if (wr_valid) m_mem[wr_addr] = wr_data;
    if (!reset) begin
      model_reset();
    end else if (g >= 0) begin
      m_v = '0;
      m_v[g] = 1'b1;
      m_d = m_mem[rd_req_addr[g*AW +: AW]];
      m_last = g;
      m_cnt++;
    end else begin
      m_v = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rd_req_valid = '0;
    wr_valid = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    rd_req_valid = '0;
    wr_valid = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rd_req_valid = 4'b1111;
    set_addrs(0);
    wr_valid = 1'b1;
    wr_addr = 12'h000;
    wr_data = 8'h3C;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if ({rspv_a, rspv_b, rspd_a, rspd_b} !== {4'b0000, 4'b0000, 8'h00, 8'h00}) begin
        bad++;
        $display("FAIL reset_rsp: got v=%b/%b d=%h/%h want v=0 d=00", rspv_a, rspv_b, rspd_a, rspd_b);
      end
      total++;
      if ({gcnt_a, gcnt_b, rrst_a, rrst_b} !== {32'd0, 32'd0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL reset_cnt: got cnt=%0d/%0d ram_reset=%b/%b want 0 and 1", gcnt_a, gcnt_b, rrst_a, rrst_b);
      end
      total++;
      if ({obs_rdy_a, obs_rdy_b} !== {4'b0001, 4'b0001}) begin
        bad++;
        $display("FAIL reset_ready: got %b/%b want 0001", obs_rdy_a, obs_rdy_b);
      end
    end
    reset = 1'b1;
    wr_valid = 1'b0;
    cycle();
    total++;
    if ({obs_rdy_a, obs_rdy_b} !== {4'b0001, 4'b0001} || m_grant !== 4'b0001) begin
      bad++;
      $display("FAIL first_grant: got %b/%b want 0001", obs_rdy_a, obs_rdy_b);
    end
    total++;
    if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0001, 8'h3C, 4'b0001, 8'h3C}) begin
      bad++;
      $display("FAIL first_rsp: got v=%b/%b d=%h/%h want 0001 3c", rspv_a, rspv_b, rspd_a, rspd_b);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] lit;
    do_reset();
    for (int i = 0; i < N; i++) write_word(16'h010 + i, 8'hA0 + 8'(i));
    rd_req_valid = 4'b1111;
    set_addrs(12'h010);
    for (int c = 0; c < 8; c++) begin
      cycle();
      lit = 4'b0001 << (c % N);
      total++;
      if ({obs_rdy_a, obs_rdy_b} !== {m_grant, m_grant} || m_grant !== lit) begin
        bad++;
        $display("FAIL rotation_ready c=%0d: got %b/%b want %b", c, obs_rdy_a, obs_rdy_b, lit);
      end
      total++;
      if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {lit, 8'hA0 + 8'(c % N), lit, 8'hA0 + 8'(c % N)}) begin
        bad++;
        $display("FAIL rotation_rsp c=%0d: got v=%b/%b d=%h/%h want %b %h", c, rspv_a, rspv_b, rspd_a, rspd_b, lit, m_d);
      end
    end
    total++;
    if ({gcnt_a, gcnt_b} !== {32'd8, 32'd8}) begin
      bad++;
      $display("FAIL rotation_count: got %0d/%0d want 8", gcnt_a, gcnt_b);
    end
  endtask

  task automatic test_sparse();
    logic [N-1:0] lit;
    rd_req_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      cycle();
      lit = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      total++;
      if ({obs_rdy_a, obs_rdy_b} !== {lit, lit} || m_grant !== lit) begin
        bad++;
        $display("FAIL sparse_ready c=%0d: got %b/%b want %b", c, obs_rdy_a, obs_rdy_b, lit);
      end
      total++;
      if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {m_v, m_d, m_v, m_d}) begin
        bad++;
        $display("FAIL sparse_rsp c=%0d: got v=%b/%b d=%h/%h want %b %h", c, rspv_a, rspv_b, rspd_a, rspd_b, m_v, m_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    rd_req_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      rd_req_addr[2*AW +: AW] = AW'(12'h010 + c);
      cycle();
      total++;
      if ({obs_rdy_a, obs_rdy_b} !== {4'b0100, 4'b0100}) begin
        bad++;
        $display("FAIL b2b_ready c=%0d: got %b/%b want 0100", c, obs_rdy_a, obs_rdy_b);
      end
      total++;
      if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0100, 8'hA0 + 8'(c), 4'b0100, 8'hA0 + 8'(c)}) begin
        bad++;
        $display("FAIL b2b_rsp c=%0d: got v=%b/%b d=%h/%h want 0100 %h", c, rspv_a, rspv_b, rspd_a, rspd_b, 8'hA0 + 8'(c));
      end
    end
  endtask

  task automatic test_forwarding();
    write_word(12'h7FF, 8'h11);
    rd_req_valid = 4'b0100;
    rd_req_addr[2*AW +: AW] = 12'h7FF;
    wr_valid = 1'b1;
    wr_addr = 12'h7FF;
    wr_data = 8'h5C;
    cycle();
    total++;
    if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0100, 8'h5C, 4'b0100, 8'h5C} || m_d !== 8'h5C) begin
      bad++;
      $display("FAIL fwd_rsp: got v=%b/%b d=%h/%h want 0100 5c", rspv_a, rspv_b, rspd_a, rspd_b);
    end
    wr_valid = 1'b0;
    cycle();
    total++;
    if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0100, 8'h5C, 4'b0100, 8'h5C}) begin
      bad++;
      $display("FAIL fwd_after: got v=%b/%b d=%h/%h want 0100 5c", rspv_a, rspv_b, rspd_a, rspd_b);
    end
    rd_req_valid = 4'b0000;
    cycle();
    total++;
    if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0000, 8'h5C, 4'b0000, 8'h5C}) begin
      bad++;
      $display("FAIL rsp_hold: got v=%b/%b d=%h/%h want 0000 5c", rspv_a, rspv_b, rspd_a, rspd_b);
    end
  endtask

  task automatic test_midflight_reset();
    set_addrs(12'h010);
    rd_req_valid = 4'b0010;
    cycle();
    reset = 1'b0;
    rd_req_valid = 4'b1111;
    model_reset();
    #1;
    total++;
    if ({rspv_a, rspv_b, ready_a, ready_b, gcnt_a, gcnt_b} !== {4'b0000, 4'b0000, 4'b0001, 4'b0001, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL midreset_state: got v=%b/%b rdy=%b/%b cnt=%0d/%0d want 0000 0001 0", rspv_a, rspv_b, ready_a, ready_b, gcnt_a, gcnt_b);
    end
    for (int c = 0; c < 2; c++) begin
      cycle();
      total++;
      if ({rspv_a, rspv_b} !== {4'b0000, 4'b0000}) begin
        bad++;
        $display("FAIL midreset_rsp c=%0d: got %b/%b want 0000", c, rspv_a, rspv_b);
      end
    end
    reset = 1'b1;
    cycle();
    total++;
    if ({obs_rdy_a, obs_rdy_b} !== {4'b0001, 4'b0001}) begin
      bad++;
      $display("FAIL midreset_first: got %b/%b want 0001", obs_rdy_a, obs_rdy_b);
    end
    total++;
    if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {4'b0001, 8'hA0, 4'b0001, 8'hA0}) begin
      bad++;
      $display("FAIL midreset_rsp_after: got v=%b/%b d=%h/%h want 0001 a0", rspv_a, rspv_b, rspd_a, rspd_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 8; i++) write_word(12'h020 + i, 8'($urandom));
    for (int c = 0; c < 400; c++) begin
      rd_req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) rd_req_addr[i*AW +: AW] = AW'(12'h020 + $urandom_range(0, 7));
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr = AW'(12'h020 + $urandom_range(0, 7));
      wr_data = 8'($urandom);
      cycle();
      total++;
      if ({obs_rdy_a, obs_rdy_b} !== {m_grant, m_grant}) begin
        bad++;
        $display("FAIL random_ready c=%0d: got %b/%b want %b", c, obs_rdy_a, obs_rdy_b, m_grant);
      end
      total++;
      if ({rspv_a, rspd_a, rspv_b, rspd_b} !== {m_v, m_d, m_v, m_d}) begin
        bad++;
        $display("FAIL random_rsp c=%0d: got v=%b/%b d=%h/%h want %b %h", c, rspv_a, rspv_b, rspd_a, rspd_b, m_v, m_d);
      end
    end
    wr_valid = 1'b0;
    total++;
    if ({gcnt_a, gcnt_b} !== {32'(m_cnt), 32'(m_cnt)}) begin
      bad++;
      $display("FAIL random_count: got %0d/%0d want %0d", gcnt_a, gcnt_b, m_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_reset();
    reset = 1'b1;
    rd_req_valid = '0;
    rd_req_addr = '0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #2;
    test_reset();
    test_rotation();
    test_sparse();
    test_back_to_back();
    test_forwarding();
    test_midflight_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
